mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Command sequencer upstream of the 16x32 register-file memory. Accepts host read/write commands over a valid/ready interface, buffers them in a small FIFO, and drives the memory port (mem_en, mem_addr, mem_data_in). For reads, it captures mem_data_out / mem_valid_out and returns a response on a second valid/ready interface. It is the only master of the memory port.

Parameters:
DATA_W, 32, data width; matches the memory word width.
ADDR_W, 4, address width; covers 16 words.
FIFO_DEPTH, 4, command FIFO entries; power of two, minimum 2.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  reset, asynchronous, active-high.
cmd_valid  in  1  host command valid.
cmd_ready  out  1  FIFO can accept a command.
cmd_wr  in  1  1 = write, 0 = read.
cmd_addr  in  ADDR_W  command address.
cmd_wdata  in  DATA_W  write data; ignored for reads.
rsp_valid  out  1  read response valid.
rsp_ready  in  1  host accepts the response.
rsp_rdata  out  DATA_W  read data.
rsp_err  out  1  memory did not flag valid on the capture cycle.
mem_en  out  1  to memory: 1 = write, 0 = read.
mem_addr  out  ADDR_W  to memory.
mem_data_in  out  DATA_W  to memory.
mem_data_out  in  DATA_W  from memory; registered read data.
mem_valid_out  in  1  from memory.
busy  out  1  FIFO non-empty or FSM not in IDLE.
wr_cnt  out  16  completed writes; wraps at 2^16.
rd_cnt  out  16  completed reads; counted at the response handshake; wraps.

Behaviour:
- Reset (async assert, sync release) clears:
  - FIFO pointers and count.
  - FSM to IDLE.
  - cmd_ready=0 during reset, 1 on the first cycle after release.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - mem_en=0, mem_addr=0, mem_data_in=0.
  - wr_cnt=0, rd_cnt=0, busy=0.
- Reset mid-operation: in-flight and queued commands are discarded; no response is produced for them.
- Command FIFO:
  - Push when cmd_valid && cmd_ready.
  - cmd_ready = !full. Full is computed from the registered count, so when full, a pop in the same cycle does not raise cmd_ready until the next cycle.
  - Push and pop in the same cycle (not full) leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, WR, RD, CAP, RSP. Memory outputs are decoded from the registered state and the cur_addr / cur_wdata registers.
  - IDLE: mem_en=0, mem_addr=cur_addr. If FIFO non-empty, pop the head into cur_wr/cur_addr/cur_wdata; go to WR if cur_wr, else RD.
  - WR (1 cycle): mem_en=1, mem_addr=cur_addr, mem_data_in=cur_wdata. Memory writes on the closing edge; wr_cnt increments on that edge. Next state is IDLE.
  - RD (1 cycle): mem_en=0, mem_addr=cur_addr. Memory registers its read on the closing edge. Next state is CAP.
  - CAP (1 cycle): mem_en=0, addr held. On the closing edge, rsp_rdata<=mem_data_out, rsp_err<=!mem_valid_out, rsp_valid<=1. Next state is RSP.
  - RSP: hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready. On the handshake edge: rsp_valid<=0, rd_cnt++, next state IDLE. rsp_ready is not required before rsp_valid.
- Latency with an empty FIFO:
  - Write: accepted cycle 0, mem_en=1 in cycle 2.
  - Read: accepted cycle 0, rsp_valid high from cycle 4.
- Throughput:
  - Writes: one per 2 cycles.
  - Reads: one per 4 cycles plus host stall.
- Ordering:
  - Commands execute strictly in acceptance order.
  - Read-after-write to the same address returns the new data; the minimum 2-cycle gap guarantees this.
- While in RSP with rsp_ready low, the FIFO keeps accepting commands until full; no command is popped.
- mem_en is never 1 outside WR, so the memory is never written unintentionally.

Test Plan:
- Reset, then write addr 3 = 0xDEADBEEF, then read addr 3 with rsp_ready=1 -> mem_en=1 for exactly one cycle (cycle 2); rsp_valid in cycle 4 of the read; rsp_rdata=0xDEADBEEF, rsp_err=0; wr_cnt=1, rd_cnt=1.
- Back-to-back: 5 writes to addrs 0..4 (data = addr*0x11111111) pushed every cycle -> cmd_ready drops after the 4th accepted command; all 5 complete in order; reading addrs 0..4 returns 0x00000000..0x44444444.
- Response stall: read addr 2 with rsp_ready=0 for 10 cycles, then 3 writes pushed -> rsp_valid and rsp_rdata stable throughout; writes not issued until the handshake; busy=1 throughout.
- Memory fault: force mem_valid_out=0 during CAP -> rsp_err=1 on the response; rsp_err=0 on the next good read.
- Reset asserted asynchronously mid-RD with 3 commands queued -> outputs zero immediately without waiting for a clock edge; no response after release; cmd_ready=1, counters=0.
- Counter wrap: preload 65535 writes (or force wr_cnt) -> one more write gives wr_cnt=0.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: command sequencer and sole master of the 16x32 register-file
// memory port. Host commands arrive on a valid/ready interface and are queued in
// a small FIFO. A five-state FSM (IDLE, WR, RD, CAP, RSP) replays them to the
// memory one at a time. Read results return on a second valid/ready interface.
//
// Ports
//   clk, rst                         clock; asynchronous active-high reset
//   cmd_valid/cmd_ready              host command handshake
//   cmd_wr/cmd_addr/cmd_wdata        command payload (1 = write)
//   rsp_valid/rsp_ready              read response handshake
//   rsp_rdata/rsp_err                read data; err = memory valid was low at capture
//   mem_en/mem_addr/mem_data_in      memory request (mem_en = 1 writes)
//   mem_data_out/mem_valid_out       registered memory read data and valid
//   busy                             queue non-empty or FSM active
//   wr_cnt/rd_cnt                    completed write/read counters (wrap)
module mem_access_ctrl #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_valid_out,
    output logic              busy,
    output logic [15:0]       wr_cnt,
    output logic [15:0]       rd_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_RD   = 3'd2,
        S_CAP  = 3'd3,
        S_RSP  = 3'd4
    } state_t;

    // Command queue storage (no reset: only entries between the pointers are live)
    logic              fifo_wr_q   [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ready_en_q;

    state_t            state_q;
    logic [ADDR_W-1:0] cur_addr_q;
    logic [DATA_W-1:0] cur_wdata_q;
    logic              mem_en_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic [15:0]       wr_cnt_q;
    logic [15:0]       rd_cnt_q;

    logic              full_s;
    logic              empty_s;
    logic              push_s;
    logic              pop_s;

    // Full is taken from the registered count, so a pop never raises ready in the same cycle.
    assign full_s    = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_s   = (count_q == {CNT_W{1'b0}});
    // ready_en_q keeps cmd_ready low while reset is applied.
    assign cmd_ready = ready_en_q & ~full_s;
    assign push_s    = cmd_valid & cmd_ready;
    assign pop_s     = (state_q == S_IDLE) & ~empty_s;

    assign mem_en      = mem_en_q;
    assign mem_addr    = cur_addr_q;
    assign mem_data_in = cur_wdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign wr_cnt      = wr_cnt_q;
    assign rd_cnt      = rd_cnt_q;
    assign busy        = (state_q != S_IDLE) | ~empty_s;

    // Queue pointer and occupancy next-state; pointers wrap naturally at a power-of-two depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1'b1);
            2'b01:   count_d = count_q - CNT_W'(1'b1);
            default: count_d = count_q;
        endcase
    end

    // Queue pointer, occupancy and ready-enable registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            ready_en_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_en_q <= 1'b1;
        end
    end

    // Queue storage write on an accepted command.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_wr_q[wr_ptr_q]   <= cmd_wr;
            fifo_addr_q[wr_ptr_q] <= cmd_addr;
            fifo_data_q[wr_ptr_q] <= cmd_wdata;
        end
    end

    // Sequencer FSM with registered memory request, response and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= {ADDR_W{1'b0}};
            cur_wdata_q <= {DATA_W{1'b0}};
            mem_en_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= {DATA_W{1'b0}};
            rsp_err_q   <= 1'b0;
            wr_cnt_q    <= 16'd0;
            rd_cnt_q    <= 16'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!empty_s) begin
                        cur_addr_q  <= fifo_addr_q[rd_ptr_q];
                        cur_wdata_q <= fifo_data_q[rd_ptr_q];
                        // mem_en is raised only on entry to WR and dropped on its exit.
                        if (fifo_wr_q[rd_ptr_q]) begin
                            state_q  <= S_WR;
                            mem_en_q <= 1'b1;
                        end else begin
                            state_q  <= S_RD;
                        end
                    end
                end
                S_WR: begin
                    mem_en_q <= 1'b0;
                    wr_cnt_q <= wr_cnt_q + 16'd1;
                    state_q  <= S_IDLE;
                end
                S_RD: begin
                    state_q <= S_CAP;
                end
                S_CAP: begin
                    rsp_rdata_q <= mem_data_out;
                    rsp_err_q   <= ~mem_valid_out;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RSP;
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rd_cnt_q    <= rd_cnt_q + 16'd1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    mem_en_q    <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed testbench for mem_access_ctrl with a behavioural 16x32 register-file model.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_wr;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_en;
    logic [3:0]  mem_addr;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out = 32'd0;
    logic        mem_valid_out = 1'b0;
    logic        busy;
    logic [15:0] wr_cnt, rd_cnt;

    logic        mem_fault = 1'b0;
    logic [31:0] mem_arr [16];
    int          en_cnt = 0;
    int          rsp_seen = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    mem_access_ctrl #(.DATA_W(32), .ADDR_W(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out), .mem_valid_out(mem_valid_out),
        .busy(busy), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
    );

    always #5 clk = ~clk;

    // Memory model: synchronous write, registered read data and valid flag.
    always @(posedge clk) begin
        if (mem_en) mem_arr[mem_addr] <= mem_data_in;
        mem_data_out  <= mem_arr[mem_addr];
        mem_valid_out <= ~mem_fault;
    end

    // Activity monitors: count write strobes and response-valid cycles.
    always @(posedge clk) begin
        if (mem_en)    en_cnt   <= en_cnt + 1;
        if (rsp_valid) rsp_seen <= rsp_seen + 1;
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic send(input logic wr, input logic [3:0] a, input logic [31:0] d);
        bit done;
        done = 1'b0;
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_wdata = d;
        for (int i = 0; i < 40 && !done; i++) begin
            if (cmd_ready) done = 1'b1;
            step();
        end
        cmd_valid = 1'b0;
        check("cmd_accepted", 32'(done), 32'd1);
    endtask

    task automatic wait_rsp();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (rsp_valid) seen = 1'b1;
            else step();
        end
        check("rsp_arrived", 32'(seen), 32'd1);
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 60 && !idle; i++) begin
            if (!busy) idle = 1'b1;
            else step();
        end
        check("idle_reached", 32'(idle), 32'd1);
    endtask

    task automatic read_expect(input string tag, input logic [3:0] a,
                               input logic [31:0] exp_d, input logic exp_err);
        rsp_ready = 1'b1;
        send(1'b0, a, 32'd0);
        wait_rsp();
        check({tag, "_data"}, rsp_rdata, exp_d);
        check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        step();
    endtask

    initial begin
        int en0, rs0;
        logic [31:0] dd;
        int a;
        rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = 4'd0; cmd_wdata = 32'd0;
        rsp_ready = 1'b0;
        #1;
        // Reset state
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_outputs", {rsp_valid, rsp_err, mem_en, busy, mem_addr}, 32'd0);
        check("rst_counters", {wr_cnt, rd_cnt}, 32'd0);
        step(); step();
        rst = 1'b0;
        step();
        check("rel_cmd_ready", 32'(cmd_ready), 32'd1);

        // Write latency: accepted in cycle 0, mem_en in cycle 2 only
        en0 = en_cnt;
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 4'd3; cmd_wdata = 32'hDEADBEEF;
        step();
        cmd_valid = 1'b0;
        check("wr_c1_en", 32'(mem_en), 32'd0);
        step();
        check("wr_c2_en", 32'(mem_en), 32'd1);
        check("wr_c2_addr", 32'(mem_addr), 32'd3);
        check("wr_c2_data", mem_data_in, 32'hDEADBEEF);
        step();
        check("wr_c3_en", 32'(mem_en), 32'd0);
        check("wr_cnt_1", 32'(wr_cnt), 32'd1);
        check("wr_en_pulses", 32'(en_cnt - en0), 32'd1);

        // Read latency: accepted in cycle 0, response in cycle 4
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 4'd3;
        step();
        cmd_valid = 1'b0;
        step(); step();
        check("rd_c3_valid", 32'(rsp_valid), 32'd0);
        step();
        check("rd_c4_valid", 32'(rsp_valid), 32'd1);
        check("rd_c4_data", rsp_rdata, 32'hDEADBEEF);
        check("rd_c4_err", 32'(rsp_err), 32'd0);
        step();
        check("rd_after_hs", 32'(rsp_valid), 32'd0);
        check("rd_cnt_1", 32'(rd_cnt), 32'd1);

        // Response stall while five writes are pushed every cycle
        rsp_ready = 1'b0;
        send(1'b0, 4'd3, 32'd0);
        wait_rsp();
        en0 = en_cnt;
        for (int k = 0; k < 10; k++) begin
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_data", rsp_rdata, 32'hDEADBEEF);
            check("stall_busy", 32'(busy), 32'd1);
            check("stall_ready", 32'(cmd_ready), (k < 4) ? 32'd1 : 32'd0);
            a = (k < 4) ? k : 4;
            dd = 32'(a) * 32'h11111111;
            cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 4'(a); cmd_wdata = dd;
            step();
        end
        check("stall_no_wr", 32'(en_cnt - en0), 32'd0);
        check("stall_rd_cnt", 32'(rd_cnt), 32'd1);
        rsp_ready = 1'b1;
        step();
        check("stall_hs_valid", 32'(rsp_valid), 32'd0);
        check("stall_rd_cnt2", 32'(rd_cnt), 32'd2);
        send(1'b1, 4'd4, 32'h44444444);
        wait_idle();
        check("b2b_wr_cnt", 32'(wr_cnt), 32'd6);
        check("b2b_en_pulses", 32'(en_cnt - en0), 32'd5);
        for (int k = 0; k < 5; k++) begin
            read_expect("b2b_rd", 4'(k), 32'(k) * 32'h11111111, 1'b0);
        end
        check("b2b_rd_cnt", 32'(rd_cnt), 32'd7);

        // Memory fault at capture, then a good read
        mem_fault = 1'b1;
        read_expect("fault", 4'd1, 32'h11111111, 1'b1);
        mem_fault = 1'b0;
        read_expect("good", 4'd2, 32'h22222222, 1'b0);
        check("fault_rd_cnt", 32'(rd_cnt), 32'd9);

        // Asynchronous reset in RD with three commands queued
        rsp_ready = 1'b0;
        send(1'b0, 4'd0, 32'd0);
        wait_rsp();
        send(1'b0, 4'd1, 32'd0);
        send(1'b1, 4'd5, 32'h55555555);
        send(1'b1, 4'd6, 32'h66666666);
        send(1'b1, 4'd7, 32'h77777777);
        check("q_full_ready", 32'(cmd_ready), 32'd0);
        rsp_ready = 1'b1;
        step();
        step();
        check("pre_rst_addr", 32'(mem_addr), 32'd1);
        check("pre_rst_busy", 32'(busy), 32'd1);
        check("pre_rst_rd_cnt", 32'(rd_cnt), 32'd10);
        #2 rst = 1'b1;
        #1;
        check("async_ready", 32'(cmd_ready), 32'd0);
        check("async_outs", {rsp_valid, rsp_err, mem_en, busy, mem_addr}, 32'd0);
        check("async_counters", {wr_cnt, rd_cnt}, 32'd0);
        check("async_rdata", rsp_rdata, 32'd0);
        rs0 = rsp_seen;
        en0 = en_cnt;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        step();
        check("post_rst_ready", 32'(cmd_ready), 32'd1);
        for (int k = 0; k < 10; k++) step();
        check("post_rst_no_rsp", 32'(rsp_seen - rs0), 32'd0);
        check("post_rst_no_wr", 32'(en_cnt - en0), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_counters", {wr_cnt, rd_cnt}, 32'd0);

        // Write counter wrap
        force dut.wr_cnt_q = 16'hFFFF;
        #1;
        release dut.wr_cnt_q;
        check("wrap_preload", 32'(wr_cnt), 32'h0000FFFF);
        step();
        send(1'b1, 4'd9, 32'hA5A5A5A5);
        wait_idle();
        check("wrap_wr_cnt", 32'(wr_cnt), 32'd0);
        read_expect("wrap_rd", 4'd9, 32'hA5A5A5A5, 1'b0);
        check("wrap_rd_cnt", 32'(rd_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
